// File: rtl/ascon_pkg.sv
// Shared types and sizing helpers for the Ascon input packer.
package ascon_pkg;

    // Packer sequencing states.
    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        VALID = 2'd2
    } packer_state_e;

    localparam int unsigned BUF_DEPTH_DEF = 4;

    // Index width for n entries; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 1) begin
            idx_w = 1;
        end else begin
            idx_w = w;
        end
    endfunction

    // Word-index width for the default buffer depth.
    localparam int unsigned WIDX_W = idx_w(2 * BUF_DEPTH_DEF);

endpackage

// File: rtl/ascon_stage_buf.sv
// Staging buffer: packs 32-bit words into 64-bit blocks (low half first),
// raises stage_full on the last slot or s_last_i, and zeroes on copy.
module ascon_stage_buf
    import ascon_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       clear_i,
    input  logic                       copy_i,
    input  logic [31:0]                s_data_i,
    input  logic                       s_valid_i,
    input  logic                       s_last_i,
    output logic                       s_ready_o,
    output logic [BUF_DEPTH-1:0][63:0] stage_o,
    output logic                       stage_full_o
);

    localparam int unsigned WW = idx_w(2 * BUF_DEPTH);
    localparam int unsigned BW = idx_w(BUF_DEPTH);
    localparam logic [WW-1:0] W_LAST = WW'(2 * BUF_DEPTH - 1);

    logic [BUF_DEPTH-1:0][63:0] stage_r;
    logic [WW-1:0]              w_r;
    logic                       stage_full_r;

    logic                       accept_s;
    logic                       seal_s;
    logic [BW-1:0]              blk_s;

    // Handshake decode: target block, accept strobe and whether this word seals the stage
    always_comb begin
        accept_s = 1'b0;
        seal_s   = 1'b0;
        blk_s    = BW'(w_r >> 1);
        if (s_valid_i && !stage_full_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((w_r == W_LAST) || s_last_i) begin
            seal_s = 1'b1;
        end else begin
            seal_s = 1'b0;
        end
    end

    // Fill state: half-select writes, word index, full flag; copy empties the stage for zero padding
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i) begin
            stage_r      <= '0;
            w_r          <= '0;
            stage_full_r <= 1'b0;
        end else if (copy_i) begin
            stage_r      <= '0;
            w_r          <= '0;
            stage_full_r <= 1'b0;
        end else if (accept_s) begin
            if (w_r[0] == 1'b0) begin
                stage_r[blk_s][31:0] <= s_data_i;
            end else begin
                stage_r[blk_s][63:32] <= s_data_i;
            end
            if (seal_s) begin
                stage_full_r <= 1'b1;
                w_r          <= '0;
            end else begin
                stage_full_r <= 1'b0;
                w_r          <= w_r + WW'(1'b1);
            end
        end else begin
            stage_r      <= stage_r;
            w_r          <= w_r;
            stage_full_r <= stage_full_r;
        end
    end

    assign s_ready_o    = !stage_full_r;
    assign stage_o      = stage_r;
    assign stage_full_o = stage_full_r;

endmodule

// File: rtl/ascon_in_packer.sv
// Ascon input packer: double-buffers a 32-bit word stream into BUF_DEPTH
// 64-bit blocks, primes the presented buffer, then refills on request.
module ascon_in_packer
    import ascon_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       clear_i,
    input  logic [31:0]                s_data_i,
    input  logic                       s_valid_i,
    input  logic                       s_last_i,
    output logic                       s_ready_o,
    input  logic                       data_req_i,
    output logic                       data_valid_o,
    output logic [BUF_DEPTH-1:0][63:0] buf_o,
    output logic                       primed_o,
    output logic                       starved_o,
    output logic [CNT_W-1:0]           bufs_o
);

    logic [BUF_DEPTH-1:0][63:0] stage_s;
    logic                       stage_full_s;
    logic                       copy_s;
    logic                       starved_s;

    packer_state_e              state_r;
    logic [BUF_DEPTH-1:0][63:0] buf_r;
    logic                       primed_r;
    logic                       data_valid_r;
    logic [CNT_W-1:0]           bufs_r;

    ascon_stage_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_stage (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .clear_i      (clear_i),
        .copy_i       (copy_s),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_last_i     (s_last_i),
        .s_ready_o    (s_ready_o),
        .stage_o      (stage_s),
        .stage_full_o (stage_full_s)
    );

    // Copy decision: prime as soon as a stage is full, later only on a wrapper request
    always_comb begin
        copy_s = 1'b0;
        case (state_r)
            PRIME: begin
                if (stage_full_s) begin
                    copy_s = 1'b1;
                end else begin
                    copy_s = 1'b0;
                end
            end
            RUN: begin
                if (data_req_i && stage_full_s) begin
                    copy_s = 1'b1;
                end else begin
                    copy_s = 1'b0;
                end
            end
            VALID: begin
                copy_s = 1'b0;
            end
            default: begin
                copy_s = 1'b0;
            end
        endcase
    end

    // Starvation flag: the wrapper is asking in RUN but nothing is staged yet
    always_comb begin
        starved_s = 1'b0;
        if ((state_r == RUN) && data_req_i && !stage_full_s) begin
            starved_s = 1'b1;
        end else begin
            starved_s = 1'b0;
        end
    end

    // Sequencer: move stage into the presented buffer, count buffers, pulse valid on refills only
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i) begin
            state_r      <= PRIME;
            buf_r        <= '0;
            primed_r     <= 1'b0;
            data_valid_r <= 1'b0;
            bufs_r       <= '0;
        end else begin
            case (state_r)
                PRIME: begin
                    data_valid_r <= 1'b0;
                    if (copy_s) begin
                        buf_r    <= stage_s;
                        bufs_r   <= bufs_r + CNT_W'(1'b1);
                        primed_r <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        state_r  <= PRIME;
                    end
                end
                RUN: begin
                    if (copy_s) begin
                        buf_r        <= stage_s;
                        bufs_r       <= bufs_r + CNT_W'(1'b1);
                        data_valid_r <= 1'b1;
                        state_r      <= VALID;
                    end else begin
                        data_valid_r <= 1'b0;
                        state_r      <= RUN;
                    end
                end
                VALID: begin
                    // Wrapper drops its request after seeing valid, so it is not sampled here.
                    data_valid_r <= 1'b0;
                    state_r      <= RUN;
                end
                default: begin
                    data_valid_r <= 1'b0;
                    state_r      <= PRIME;
                end
            endcase
        end
    end

    assign data_valid_o = data_valid_r;
    assign buf_o        = buf_r;
    assign primed_o     = primed_r;
    assign starved_o    = starved_s;
    assign bufs_o       = bufs_r;

endmodule

// File: tb/tb_ascon_in_packer.sv
// Scoreboard bench for ascon_in_packer: the driver feeds a reference model
// that cuts the accepted word stream into zero-padded buffers; a monitor
// pops and compares whenever the DUT presents a buffer.
module tb_ascon_in_packer;

    localparam int BD = 4;
    localparam int CW = 8;
    typedef logic [BD-1:0][63:0] blk_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        data_req;
    logic        data_valid;
    blk_t        buf_s;
    logic        primed;
    logic        starved;
    logic [CW-1:0] bufs;

    ascon_in_packer #(.BUF_DEPTH(BD), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
        .data_req_i(data_req), .data_valid_o(data_valid), .buf_o(buf_s),
        .primed_o(primed), .starved_o(starved), .bufs_o(bufs)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    blk_t exp_q[$];
    logic [31:0] cur_q[$];
    int dv_count = 0;
    int prime_count = 0;
    int deliv = 0;
    int accepts = 0;
    int stall_cycles = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference model: words are cut into buffers of 2*BD words or at s_last; gaps stay zero.
    task automatic model_accept(input logic [31:0] d, input bit lst);
        blk_t b;
        cur_q.push_back(d);
        if (cur_q.size() == 2 * BD || lst) begin
            b = '0;
            foreach (cur_q[i]) b[i / 2][(i % 2) * 32 +: 32] = cur_q[i];
            exp_q.push_back(b);
            cur_q.delete();
        end
    endtask

    // Word driver; starts and ends at a negedge. last_at < 0 means no s_last.
    task automatic send(input int n, input logic [31:0] base, input bit rnd, input int last_at, input int max_gap);
        logic [31:0] d;
        bit lst;
        bit done;
        int t;
        for (int k = 0; k < n; k++) begin
            d   = rnd ? $urandom : base + 32'(k);
            lst = (k == last_at);
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) begin
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    @(negedge clk);
                end
            end
            s_valid = 1'b1;
            s_data  = d;
            s_last  = lst;
            done = 1'b0;
            t = 0;
            while (!done && t < 300) begin
                if (s_ready === 1'b1) done = 1'b1;
                else stall_cycles++;
                @(posedge clk);
                if (done) begin
                    accepts++;
                    model_accept(d, lst);
                end
                @(negedge clk);
                t++;
            end
            if (!done) timeout_fail("accept_wait");
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Wrapper-style request: raise, wait for the valid pulse, drop. lat = extra negedges waited.
    task automatic request(output int lat);
        int t;
        data_req = 1'b1;
        @(negedge clk);
        t = 0;
        while (data_valid !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout_fail("request_wait");
        data_req = 1'b0;
        lat = t;
    endtask

    task automatic wait_primed();
        int t;
        t = 0;
        while (primed !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) timeout_fail("prime_wait");
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_q.delete();
        cur_q.delete();
    endtask

    // Monitor: compare every presented buffer (prime or refill pulse) against the scoreboard.
    initial begin
        logic prev_primed;
        blk_t e;
        prev_primed = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (primed === 1'b1 && prev_primed !== 1'b1) begin
                    prime_count++;
                    deliv++;
                    if (exp_q.size() == 0) timeout_fail("prime_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        check("prime_buf", buf_s, e);
                    end
                    check("prime_bufs", bufs, deliv % (1 << CW));
                end
                if (data_valid === 1'b1) begin
                    dv_count++;
                    deliv++;
                    if (exp_q.size() == 0) timeout_fail("refill_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        check("refill_buf", buf_s, e);
                    end
                    check("refill_bufs", bufs, deliv % (1 << CW));
                end
                prev_primed = primed;
                if (clear === 1'b1) begin
                    deliv = 0;
                    prev_primed = 1'b0;
                end
            end
        end
    end

    initial begin
        int lat;
        int sc;
        int n0;
        int a0;
        rst_n = 1'b0; clear = 1'b0; s_data = 32'h0; s_valid = 1'b0; s_last = 1'b0; data_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", s_ready, 1);
        check("rst_valid", data_valid, 0);
        check("rst_primed", primed, 0);
        check("rst_starved", starved, 0);
        check("rst_bufs", bufs, 0);
        check("rst_buf", buf_s, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        do_clear();

        // Prime with 1..8, no stalls
        send(8, 32'h1, 1'b0, -1, 0);
        repeat (3) @(negedge clk);
        check("prime_primed", primed, 1);
        check("prime_cnt", bufs, 1);
        check("prime_blk0", buf_s[0], 64'h00000002_00000001);
        check("prime_blk3", buf_s[3], 64'h00000008_00000007);
        check("prime_no_pulse", dv_count, 0);

        // Refill: staged buffer waits, then request gives a pulse in the following cycle
        send(8, 32'h11, 1'b0, -1, 0);
        repeat (2) @(negedge clk);
        check("staged_ready_low", s_ready, 0);
        data_req = 1'b1;
        @(negedge clk);
        check("refill_pulse", data_valid, 1);
        data_req = 1'b0;
        @(negedge clk);
        check("refill_pulse_end", data_valid, 0);
        check("refill_ready_back", s_ready, 1);
        check("refill_blk1", buf_s[1], 64'h00000014_00000013);
        check("refill_cnt", bufs, 2);

        // Starve: request with nothing staged, then feed a buffer under the pending request
        data_req = 1'b1;
        n0 = dv_count;
        sc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (starved === 1'b1) sc++;
        end
        check("starve_cycles", sc, 10);
        check("starve_no_pulse", dv_count, n0);
        send(8, 32'h0, 1'b1, -1, 1);
        check("starve_full_ready", s_ready, 0);
        check("starve_cleared", starved, 0);
        @(negedge clk);
        check("starve_pulse", data_valid, 1);
        data_req = 1'b0;
        @(negedge clk);
        check("starve_pulse_end", data_valid, 0);

        // Short message with s_last on the third word
        send(3, 32'hA, 1'b0, 2, 0);
        repeat (2) @(negedge clk);
        request(lat);
        check("pad_lat", lat, 0);
        check("pad_blk0", buf_s[0], 64'h0000000B_0000000A);
        check("pad_blk1", buf_s[1], 64'h00000000_0000000C);
        check("pad_blk2", buf_s[2], 64'h0);
        check("pad_blk3", buf_s[3], 64'h0);

        // Backpressure: valid held high across three buffers, random request timing
        do_clear();
        a0 = accepts;
        sc = stall_cycles;
        fork
            send(24, 32'h0, 1'b1, -1, 0);
            begin
                int l;
                wait_primed();
                repeat (2) begin
                    repeat ($urandom_range(20, 5)) @(negedge clk);
                    request(l);
                end
            end
        join
        repeat (3) @(negedge clk);
        check("bp_accepts", accepts - a0, 24);
        check("bp_stalled", (stall_cycles > sc), 1);
        check("bp_cnt", bufs, 3);
        check("bp_drained", exp_q.size(), 0);

        // Mid-operation clear discards partial stage and presented buffer
        send(5, 32'h0, 1'b1, -1, 1);
        do_clear();
        check("mclr_buf", buf_s, 0);
        check("mclr_primed", primed, 0);
        check("mclr_cnt", bufs, 0);
        check("mclr_ready", s_ready, 1);
        send(8, 32'h100, 1'b0, -1, 1);
        repeat (3) @(negedge clk);
        check("mclr_blk0", buf_s[0], 64'h00000101_00000100);
        check("mclr_blk3", buf_s[3], 64'h00000107_00000106);
        check("mclr_cnt2", bufs, 1);

        // Counter wrap: 257 buffers since clear
        do_clear();
        fork
            send(8 * 257, 32'h0, 1'b1, -1, 1);
            begin
                int l;
                wait_primed();
                repeat (256) begin
                    repeat ($urandom_range(3, 0)) @(negedge clk);
                    request(l);
                end
            end
        join
        repeat (3) @(negedge clk);
        check("wrap_cnt", bufs, 1);
        check("wrap_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
